regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised successor to the 8x8 prelude register file: configurable width and depth, two write ports, optional write-to-read bypass, optional hardwired-zero r0.
- Adds a per-register busy scoreboard for multi-cycle producers.
- The IO register feeds a 2-deep valid/ready output queue, so the core no longer has to poll a raw register output.
- Sits between decode (read addresses), execute/load writeback (write ports) and the IO block (queue consumer).

Parameters:
- WIDTH, 8, data width of each register.
- NREGS, 8, number of registers (power of two, >=4); AW = $clog2(NREGS) is derived, not overridable.
- TAP_REG, 3, index of the register mirrored on tap_out.
- IO_REG, NREGS-1, index of the register whose writes are pushed into the IO queue.
- ZERO_R0, 0, if 1 then r0 reads 0 and ignores writes and claims.
- BYPASS, 1, if 1 then reads return same-cycle write data.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- src_a  in  AW  read address A.
- src_b  in  AW  read address B.
- out_a  out  WIDTH  read data A.
- out_b  out  WIDTH  read data B.
- busy_a  out  1  scoreboard bit of src_a.
- busy_b  out  1  scoreboard bit of src_b.
- we0  in  1  write enable, port 0.
- dst0  in  AW  write address, port 0.
- in0  in  WIDTH  write data, port 0.
- we1  in  1  write enable, port 1 (higher priority).
- dst1  in  AW  write address, port 1.
- in1  in  WIDTH  write data, port 1.
- claim_en  in  1  mark claim_reg busy.
- claim_reg  in  AW  register to claim.
- tap_out  out  WIDTH  contents of TAP_REG (registered value, never bypassed).
- io_data  out  WIDTH  IO queue head.
- io_valid  out  1  queue non-empty.
- io_ready  in  1  consumer accepts head.
- io_count  out  2  queue occupancy 0..2.
- io_overflow  out  1  sticky, set on dropped push.

Behaviour:
- Reset, asynchronous and immediate: all registers 0, busy all 0, queue empty (io_valid=0, io_count=0, io_data=0), io_overflow=0. Reset mid-operation discards queued data and claims.
- Writes:
  - Register updates at posedge for each enabled port.
  - Both ports to the same dst: port 1 value wins.
  - Different dst: both update.
  - ZERO_R0=1: writes to index 0 are discarded.
- Reads are combinational.
  - BYPASS=1: if src matches an enabled dst this cycle, the write data is returned, port 1 first, then port 0, else the stored value.
  - BYPASS=0: stored value only, so new data is visible the cycle after the write.
  - ZERO_R0=1: src 0 returns 0 regardless.
- Scoreboard:
  - claim_en sets busy[claim_reg] at posedge.
  - Any effective write to a register clears its busy bit.
  - Claim and write to the same register in the same cycle: busy ends set (claim wins).
  - busy_a/busy_b are combinational lookups of the stored bits, with no bypass.
  - Claims of r0 are ignored when ZERO_R0=1.
- IO queue: 2-entry FIFO.
  - Push: one per cycle, when any port effectively writes IO_REG. The pushed value is the final resolved write value (port 1 wins).
  - Pop: when io_valid && io_ready.
  - io_data = head, io_valid = (count != 0).
  - Push and pop in the same cycle: allowed at any occupancy, including full. Count unchanged; the new entry goes behind the remaining one (at count 1 it becomes the head).
  - Push while full without pop: data dropped from the queue (the register itself still updates), count stays 2, io_overflow set. io_overflow clears only on rst.
  - Pop while empty: no effect.
  - Data is held stable while io_valid && !io_ready.
- Pointers wrap modulo 2; count is never outside 0..2.
- No other outputs are registered; read path latency is 0 cycles, write-to-stored latency is 1 cycle.

Test Plan:
- Reset then read all indices -> out_a=out_b=0, busy_a=busy_b=0, io_valid=0, io_count=0, io_overflow=0. Assert rst mid-stream with io_count=2 -> io_valid drops to 0 immediately.
- Port contention: we0 dst0=2 in0=0x11 and we1 dst1=2 in1=0x22 in the same cycle, src_a=2 -> BYPASS=1: out_a=0x22 that cycle; stored value 0x22 after. Repeat with BYPASS=0 -> out_a shows the old value (0), then 0x22 next cycle.
- ZERO_R0=1: write 0x5A to r0 and claim r0 -> out_a(src 0)=0, busy_a=0. Write 0x3C to r3 -> tap_out=0x3C the cycle after.
- Scoreboard: claim r5 -> busy_b=1 (src_b=5) next cycle. Write r5=0x77 -> busy clear next cycle. Claim r5 and write r5 in the same cycle -> busy stays 1.
- IO queue: io_ready=0, write IO_REG 0xA1, 0xA2, 0xA3 on consecutive cycles.
  - Expected: io_count 1, 2, 2; io_overflow=1; io_data=0xA1; register IO_REG=0xA3.
  - Then io_ready=1 -> pops return 0xA1, 0xA2, then io_valid=0.
- Full push-and-pop: queue holds 0xB1, 0xB2, io_ready=1, write IO_REG 0xB3 -> io_count stays 2, io_overflow unchanged at 0, next heads 0xB2 then 0xB3.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-ported register file with dual write ports, optional bypass / hardwired r0,
// a per-register busy scoreboard and a 2-deep valid/ready queue fed by IO_REG writes.
module regfile_mp #(
  parameter int WIDTH   = 8,
  parameter int NREGS   = 8,
  parameter int TAP_REG = 3,
  parameter int IO_REG  = NREGS - 1,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    src_a,
  input  logic [AW-1:0]    src_b,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             busy_a,
  output logic             busy_b,
  input  logic             we0,
  input  logic [AW-1:0]    dst0,
  input  logic [WIDTH-1:0] in0,
  input  logic             we1,
  input  logic [AW-1:0]    dst1,
  input  logic [WIDTH-1:0] in1,
  input  logic             claim_en,
  input  logic [AW-1:0]    claim_reg,
  output logic [WIDTH-1:0] tap_out,
  output logic [WIDTH-1:0] io_data,
  output logic             io_valid,
  input  logic             io_ready,
  output logic [1:0]       io_count,
  output logic             io_overflow
);
  localparam logic [AW-1:0] IO_IDX  = AW'(IO_REG);
  localparam logic [AW-1:0] TAP_IDX = AW'(TAP_REG);
  localparam bit            ZR      = (ZERO_R0 != 0);
  localparam bit            BP      = (BYPASS != 0);

  logic [NREGS-1:0][WIDTH-1:0] regs_q, regs_d;
  logic [NREGS-1:0]            busy_q, busy_d;
  logic [1:0][WIDTH-1:0]       fifo_q, fifo_d;
  logic                        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [1:0]                  cnt_q, cnt_d;
  logic                        ovf_q, ovf_d;

  logic             wr0, wr1, claim, push, pop, accept;
  logic [WIDTH-1:0] push_data;

  // "Effective" writes/claims exclude r0 when it is hardwired to zero.
  assign wr0   = we0 && !(ZR && dst0 == '0);
  assign wr1   = we1 && !(ZR && dst1 == '0);
  assign claim = claim_en && !(ZR && claim_reg == '0);

  assign out_a = (ZR && src_a == '0)           ? '0  :
                 (BP && wr1 && dst1 == src_a) ? in1 :
                 (BP && wr0 && dst0 == src_a) ? in0 : regs_q[src_a];
  assign out_b = (ZR && src_b == '0)           ? '0  :
                 (BP && wr1 && dst1 == src_b) ? in1 :
                 (BP && wr0 && dst0 == src_b) ? in0 : regs_q[src_b];
  assign busy_a  = busy_q[src_a];
  assign busy_b  = busy_q[src_b];
  assign tap_out = regs_q[TAP_IDX];

  assign push      = (wr1 && dst1 == IO_IDX) || (wr0 && dst0 == IO_IDX);
  assign push_data = (wr1 && dst1 == IO_IDX) ? in1 : in0;
  assign pop       = (cnt_q != 2'd0) && io_ready;
  // A pop frees the head slot this cycle, so a push is accepted even when full.
  assign accept    = push && ((cnt_q != 2'd2) || pop);

  assign io_data     = fifo_q[rd_ptr_q];
  assign io_valid    = (cnt_q != 2'd0);
  assign io_count    = cnt_q;
  assign io_overflow = ovf_q;

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr0) begin
      regs_d[dst0] = in0;
      busy_d[dst0] = 1'b0;
    end
    if (wr1) begin
      regs_d[dst1] = in1;
      busy_d[dst1] = 1'b0;
    end
    if (claim) busy_d[claim_reg] = 1'b1;
  end

  always_comb begin
    fifo_d   = fifo_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (accept) begin
      fifo_d[wr_ptr_q] = push_data;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    if (accept && !pop)      cnt_d = cnt_q + 2'd1;
    else if (!accept && pop) cnt_d = cnt_q - 2'd1;
    if (push && !accept) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q   <= '0;
      busy_q   <= '0;
      fifo_q   <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      ovf_q    <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      busy_q   <= busy_d;
      fifo_q   <= fifo_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Randomised + directed bench for regfile_mp: three configurations share stimulus,
// an array/queue reference model predicts reads, scoreboard and IO queue contents.
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] src_a = '0, src_b = '0, dst0 = '0, dst1 = '0, claim_reg = '0;
  logic       we0 = 1'b0, we1 = 1'b0, claim_en = 1'b0, io_ready = 1'b0;
  logic [7:0] in0 = '0, in1 = '0;

  logic [2:0][7:0] out_a, out_b, tap_out, io_data;
  logic [2:0]      busy_a, busy_b, io_valid, io_overflow;
  logic [2:0][1:0] io_count;

  int n_chk = 0;
  int n_fail = 0;

  // config 0: bypass, plain r0; config 1: no bypass; config 2: bypass, zero r0
  regfile_mp #(.BYPASS(1), .ZERO_R0(0)) dut0 (
    .clk(clk), .rst(rst), .src_a(src_a), .src_b(src_b), .out_a(out_a[0]), .out_b(out_b[0]),
    .busy_a(busy_a[0]), .busy_b(busy_b[0]), .we0(we0), .dst0(dst0), .in0(in0), .we1(we1),
    .dst1(dst1), .in1(in1), .claim_en(claim_en), .claim_reg(claim_reg), .tap_out(tap_out[0]),
    .io_data(io_data[0]), .io_valid(io_valid[0]), .io_ready(io_ready), .io_count(io_count[0]),
    .io_overflow(io_overflow[0]));
  regfile_mp #(.BYPASS(0), .ZERO_R0(0)) dut1 (
    .clk(clk), .rst(rst), .src_a(src_a), .src_b(src_b), .out_a(out_a[1]), .out_b(out_b[1]),
    .busy_a(busy_a[1]), .busy_b(busy_b[1]), .we0(we0), .dst0(dst0), .in0(in0), .we1(we1),
    .dst1(dst1), .in1(in1), .claim_en(claim_en), .claim_reg(claim_reg), .tap_out(tap_out[1]),
    .io_data(io_data[1]), .io_valid(io_valid[1]), .io_ready(io_ready), .io_count(io_count[1]),
    .io_overflow(io_overflow[1]));
  regfile_mp #(.BYPASS(1), .ZERO_R0(1)) dut2 (
    .clk(clk), .rst(rst), .src_a(src_a), .src_b(src_b), .out_a(out_a[2]), .out_b(out_b[2]),
    .busy_a(busy_a[2]), .busy_b(busy_b[2]), .we0(we0), .dst0(dst0), .in0(in0), .we1(we1),
    .dst1(dst1), .in1(in1), .claim_en(claim_en), .claim_reg(claim_reg), .tap_out(tap_out[2]),
    .io_data(io_data[2]), .io_valid(io_valid[2]), .io_ready(io_ready), .io_count(io_count[2]),
    .io_overflow(io_overflow[2]));

  // Reference model
  logic [7:0] mreg [3][8];
  bit   [7:0] mbusy [3];
  logic [7:0] exp_q [$];
  int         exp_cnt = 0;
  bit         movf = 1'b0;

  function automatic bit bp(int k); return k != 1; endfunction
  function automatic bit zr(int k); return k == 2; endfunction

  function automatic logic [7:0] m_read(int k, logic [2:0] s);
    if (zr(k) && s == 3'd0) return 8'h00;
    if (bp(k) && we1 && dst1 == s) return in1;
    if (bp(k) && we0 && dst0 == s) return in0;
    return mreg[k][s];
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 8; r++) mreg[k][r] = 8'h00;
      mbusy[k] = '0;
    end
    exp_q.delete();
    exp_cnt = 0;
    movf = 1'b0;
  endtask

  task automatic chk(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h", nm, k, act, exp);
    end
  endtask

  // Scoreboard monitor: head must match the oldest expected entry; pop on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++)
        if (io_valid[k]) begin
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL io_data dut%0d: valid with data %0h but no entry expected", k, io_data[k]);
          end else chk("io_data", k, io_data[k], exp_q[0]);
        end
      if (exp_q.size() > 0 && io_ready) void'(exp_q.pop_front());
    end
  end

  task automatic cyc(input bit w0, input logic [2:0] d0, input logic [7:0] i0,
                     input bit w1, input logic [2:0] d1, input logic [7:0] i1,
                     input bit ce, input logic [2:0] cr,
                     input logic [2:0] sa, input logic [2:0] sb, input bit rdy);
    bit pop, push;
    logic [7:0] pv;
    @(posedge clk); #1;
    we0 = w0; dst0 = d0; in0 = i0; we1 = w1; dst1 = d1; in1 = i1;
    claim_en = ce; claim_reg = cr; src_a = sa; src_b = sb; io_ready = rdy;
    @(negedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      chk("out_a", k, out_a[k], m_read(k, sa));
      chk("out_b", k, out_b[k], m_read(k, sb));
      chk("busy_a", k, 8'(busy_a[k]), 8'(mbusy[k][sa]));
      chk("busy_b", k, 8'(busy_b[k]), 8'(mbusy[k][sb]));
      chk("tap_out", k, tap_out[k], mreg[k][3]);
      chk("io_count", k, 8'(io_count[k]), 8'(exp_cnt));
      chk("io_valid", k, 8'(io_valid[k]), 8'(exp_cnt != 0));
      chk("io_overflow", k, 8'(io_overflow[k]), 8'(movf));
    end
    pop  = (exp_cnt > 0) && rdy;
    push = (w0 && d0 == 3'd7) || (w1 && d1 == 3'd7);
    pv   = (w1 && d1 == 3'd7) ? i1 : i0;
    if (push) begin
      if (exp_cnt < 2 || pop) begin
        exp_q.push_back(pv);
        if (!pop) exp_cnt++;
      end else movf = 1'b1;
    end else if (pop) exp_cnt--;
    for (int k = 0; k < 3; k++) begin
      if (w0 && !(zr(k) && d0 == 3'd0)) begin mreg[k][d0] = i0; mbusy[k][d0] = 1'b0; end
      if (w1 && !(zr(k) && d1 == 3'd0)) begin mreg[k][d1] = i1; mbusy[k][d1] = 1'b0; end
      if (ce && !(zr(k) && cr == 3'd0)) mbusy[k][cr] = 1'b1;
    end
  endtask

  task automatic idle(input logic [2:0] sa, input logic [2:0] sb, input bit rdy);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, sa, sb, rdy);
  endtask

  task automatic wr(input logic [2:0] d, input logic [7:0] v, input bit rdy);
    cyc(1, d, v, 0, 0, 0, 0, 0, d, d, rdy);
  endtask

  task automatic mid_reset();
    we0 = 1'b0; we1 = 1'b0; claim_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_io_valid", k, 8'(io_valid[k]), 8'h00);
      chk("rst_io_count", k, 8'(io_count[k]), 8'h00);
      chk("rst_tap", k, tap_out[k], 8'h00);
    end
    model_clear();
    @(negedge clk); #2 rst = 1'b0;
  endtask

  initial begin
    model_clear();
    #2;
    for (int i = 0; i < 8; i++) begin
      src_a = 3'(i); src_b = 3'(7 - i);
      #1;
      for (int k = 0; k < 3; k++) begin
        chk("rst_out_a", k, out_a[k], 8'h00);
        chk("rst_out_b", k, out_b[k], 8'h00);
        chk("rst_busy_a", k, 8'(busy_a[k]), 8'h00);
        chk("rst_busy_b", k, 8'(busy_b[k]), 8'h00);
      end
    end
    for (int k = 0; k < 3; k++) begin
      chk("rst_io_valid", k, 8'(io_valid[k]), 8'h00);
      chk("rst_io_count", k, 8'(io_count[k]), 8'h00);
      chk("rst_io_data", k, io_data[k], 8'h00);
      chk("rst_io_overflow", k, 8'(io_overflow[k]), 8'h00);
    end
    @(negedge clk); #2 rst = 1'b0;

    // same-dst contention, then visibility of stored value
    cyc(1, 2, 8'h11, 1, 2, 8'h22, 0, 0, 2, 2, 0);
    idle(2, 2, 0);
    // r0 write + claim, then tap register
    cyc(1, 0, 8'h5A, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(0, 0, 0);
    wr(3, 8'h3C, 0);
    idle(3, 3, 0);
    // scoreboard: claim, clear by write, claim+write same cycle
    cyc(0, 0, 0, 0, 0, 0, 1, 5, 5, 5, 0);
    cyc(1, 5, 8'h77, 0, 0, 0, 0, 0, 5, 5, 0);
    idle(5, 5, 0);
    cyc(0, 0, 0, 1, 5, 8'h78, 1, 5, 5, 5, 0);
    idle(5, 5, 0);
    // IO overflow then drain
    wr(7, 8'hA1, 0);
    wr(7, 8'hA2, 0);
    wr(7, 8'hA3, 0);
    idle(7, 7, 0);
    idle(7, 7, 1);
    idle(7, 7, 1);
    idle(7, 7, 1);
    // fill, then async reset with two entries queued
    wr(7, 8'hC1, 0);
    wr(7, 8'hC2, 0);
    idle(7, 7, 0);
    mid_reset();
    // full push-and-pop
    wr(7, 8'hB1, 0);
    cyc(0, 0, 0, 1, 7, 8'hB2, 0, 0, 7, 7, 0);
    cyc(1, 7, 8'hB3, 0, 0, 0, 0, 0, 7, 7, 1);
    idle(7, 7, 1);
    idle(7, 7, 1);
    idle(7, 7, 1);
    // random traffic
    for (int n = 0; n < 400; n++) begin
      cyc($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 8'($urandom),
          $urandom_range(0, 2) == 0, ($urandom_range(0, 3) == 0) ? 3'd7 : 3'($urandom_range(0, 7)),
          8'($urandom), $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1);
    end
    for (int n = 0; n < 4; n++) idle(3'(n), 3'(n + 4), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
